// File: rtl/output_display_driver.sv
// output_display_driver: 8-bit value -> decimal via sequential double-dabble -> 4-digit muxed 7-seg scan.
// Latency: load edge to new digits in the display regs = 9 cycles; scan outputs are registered (+1).
// Backpressure: none; a load while busy is held in a one-deep pending slot (latest load wins).
// Optional feature: define SIGNED_DISPLAY_EN to treat value_i as two's complement with a '-' sign digit.
module output_display_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int REFRESH_DIV = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [6:0]            seg_o,
  output logic [3:0]            an_o
);

  localparam int          RW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0]  CODE_BLANK = 4'hF;
  localparam logic [3:0]  CODE_MINUS = 4'hE;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  state_t                  state_q, state_d;
  logic                    start, step, commit;
  logic [DATA_WIDTH-1:0]   start_val, start_mag;
  logic                    start_neg;

  logic [DATA_WIDTH-1:0]   shift_q;
  logic [11:0]             bcd_q, bcd_adj;
  logic [2:0]              cnt_q;
  logic                    sign_q;
  logic                    pend_vld_q;
  logic [DATA_WIDTH-1:0]   pend_val_q;
  logic                    done_q;
  logic [3:0][3:0]         digit_q;

  logic [RW-1:0]           ref_cnt_q;
  logic [1:0]              scan_idx_q;
  logic [6:0]              seg_q;
  logic [3:0]              an_q;

  // Map a digit code to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0:       seg_of = 7'b1000000;
      4'd1:       seg_of = 7'b1111001;
      4'd2:       seg_of = 7'b0100100;
      4'd3:       seg_of = 7'b0110000;
      4'd4:       seg_of = 7'b0011001;
      4'd5:       seg_of = 7'b0010010;
      4'd6:       seg_of = 7'b0000010;
      4'd7:       seg_of = 7'b1111000;
      4'd8:       seg_of = 7'b0000000;
      4'd9:       seg_of = 7'b0010000;
      CODE_MINUS: seg_of = 7'b0111111;
      default:    seg_of = 7'b1111111;
    endcase
  endfunction

  // A load arriving in the commit cycle is newer than anything pending, so it wins.
  assign start_val = load_i ? value_i : pend_val_q;

`ifdef SIGNED_DISPLAY_EN
  assign start_neg = start_val[DATA_WIDTH-1];
  assign start_mag = start_val[DATA_WIDTH-1]
                   ? (~start_val) + {{(DATA_WIDTH-1){1'b0}}, 1'b1}
                   : start_val;
`else
  assign start_neg = 1'b0;
  assign start_mag = start_val;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (cnt_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit = 1'b1;
        if (load_i || pend_vld_q) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // Double-dabble shift register, BCD accumulator, step counter and sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else if (start) begin
      shift_q <= start_mag;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= start_neg;
    end else if (step) begin
      {bcd_q, shift_q} <= {bcd_adj[10:0], shift_q, 1'b0};
      cnt_q            <= cnt_q + 3'd1;
    end
  end

  // One-deep pending slot: filled by loads during SHIFT, consumed at COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else if (state_q == ST_SHIFT && load_i) begin
      pend_vld_q <= 1'b1;
      pend_val_q <= value_i;
    end else if (state_q == ST_COMMIT) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Display digit registers with leading-zero blanking; units digit is always shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= {4{CODE_BLANK}};
      done_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        digit_q[0] <= bcd_q[3:0];
        digit_q[1] <= (bcd_q[11:4] == 8'd0) ? CODE_BLANK : bcd_q[7:4];
        digit_q[2] <= (bcd_q[11:8] == 4'd0) ? CODE_BLANK : bcd_q[11:8];
        digit_q[3] <= sign_q ? CODE_MINUS : CODE_BLANK;
      end
    end
  end

  // Free-running refresh counter; the scan index advances on each wrap, units first.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q  <= '0;
      scan_idx_q <= '0;
    end else if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
      ref_cnt_q  <= '0;
      scan_idx_q <= scan_idx_q + 2'd1;
    end else begin
      ref_cnt_q  <= ref_cnt_q + RW'(1);
    end
  end

  // Registered pin drivers so segments and anodes switch together.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_of(digit_q[scan_idx_q]);
      an_q  <= ~(4'b0001 << scan_idx_q);
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign seg_o  = seg_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_output_display_driver.sv
// Bench for output_display_driver: directed loads; expected digit patterns go into a queue and
// a monitor pops one per done_o pulse, then compares each scanned digit once as it appears.
// Expectations for the signed variant are selected with SIGNED_DISPLAY_EN.
module tb_output_display_driver;

  localparam logic [6:0] SB = 7'h7F, SM = 7'h3F;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S8 = 7'h00;
  localparam logic [27:0] BLANK4 = {SB, SB, SB, SB};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value_i = 8'h00;
  logic       load_i = 1'b0;
  logic       busy_o, done_o;
  logic [6:0] seg_o;
  logic [3:0] an_o;

  int checks = 0;
  int failures = 0;

  logic [27:0] exp_q[$];
  logic [7:0]  vec_val[8];
  logic [27:0] vec_exp[8];

  output_display_driver #(.DATA_WIDTH(8), .REFRESH_DIV(16)) dut (
    .clk(clk), .reset(reset), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_o), .done_o(done_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_load(input logic [7:0] v);
    @(posedge clk); #1;
    value_i = v;
    load_i  = 1'b1;
    @(posedge clk); #1;
    load_i  = 1'b0;
  endtask

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'hE:    an_index = 0;
      4'hD:    an_index = 1;
      4'hB:    an_index = 2;
      4'h7:    an_index = 3;
      default: an_index = -1;
    endcase
  endfunction

  // Monitor: tracks the currently expected display image and checks each digit once.
  logic [27:0] cur = BLANK4;
  logic [3:0]  seen = 4'h0;
  bit          armed = 1'b0;
  int          idx;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1'b0;
      end else if (!armed) begin
        armed = 1'b1;
        cur   = BLANK4;
        seen  = 4'h0;
      end else if (done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          cur  = exp_q.pop_front();
          seen = 4'h0;
        end
      end else begin
        idx = an_index(an_o);
        if (idx >= 0 && !seen[idx]) begin
          seen[idx] = 1'b1;
          checks++;
          if (seg_o !== cur[idx*7 +: 7]) begin
            failures++;
            $display("FAIL digit%0d seg actual=%02h required=%02h", idx, seg_o, cur[idx*7 +: 7]);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    int busy_cnt;
    int done_cnt;
    logic [3:0] walk_exp[4];
    walk_exp = '{4'hD, 4'hB, 4'h7, 4'hE};

    vec_val[0] = 8'h05; vec_exp[0] = {SB, SB, SB, S5};
    vec_val[1] = 8'h00; vec_exp[1] = {SB, SB, SB, S0};
    vec_val[2] = 8'h64; vec_exp[2] = {SB, S1, S0, S0};
    vec_val[3] = 8'h0A; vec_exp[3] = {SB, SB, S1, S0};
    vec_val[4] = 8'h7F; vec_exp[4] = {SB, S1, S2, S7};
`ifdef SIGNED_DISPLAY_EN
    vec_val[5] = 8'hFF; vec_exp[5] = {SM, SB, SB, S1};
    vec_val[6] = 8'hFE; vec_exp[6] = {SM, SB, SB, S2};
    vec_val[7] = 8'h80; vec_exp[7] = {SM, S1, S2, S8};
`else
    vec_val[5] = 8'hFF; vec_exp[5] = {SB, S2, S5, S5};
    vec_val[6] = 8'hFE; vec_exp[6] = {SB, S2, S5, S4};
    vec_val[7] = 8'h80; vec_exp[7] = {SB, S1, S2, S8};
`endif

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", 32'(seg_o), 32'h7F);
    chk("reset_an", 32'(an_o), 32'hF);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_done", 32'(done_o), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Anode walk after release: E, D, B, 7, E at REFRESH_DIV spacing.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an_o == 4'hF && n < 10);
    chk("walk_first_an", 32'(an_o), 32'hE);
    repeat (8) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      repeat (16) @(negedge clk);
      chk("walk_an", 32'(an_o), 32'(walk_exp[w]));
    end

    // Directed conversions; the first also checks busy/done timing.
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vec_exp[v]);
      pulse_load(vec_val[v]);
      if (v == 0) begin
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
          @(negedge clk);
          if (c <= 9) begin
            busy_cnt += int'(busy_o);
            done_cnt += int'(done_o);
          end else begin
            chk("done_at_k9", 32'(done_o), 32'h1);
            chk("busy_clear_k9", 32'(busy_o), 32'h0);
          end
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd9);
        chk("done_early", 32'(done_cnt), 32'd0);
      end
      repeat (75) @(negedge clk);
    end

    // Loads while busy: 0x10 is overwritten by 0x2A, giving "3" then "42".
    exp_q.push_back({SB, SB, SB, S3});
    exp_q.push_back({SB, SB, S4, S2});
    pulse_load(8'h03);
    repeat (3) @(posedge clk); #1;
    value_i = 8'h10; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    @(posedge clk); #1;
    value_i = 8'h2A; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      busy_cnt += int'(!busy_o);
    end
    chk("busy_continuous_low_samples", 32'(busy_cnt), 32'd0);
    repeat (80) @(negedge clk);
    chk("pending_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of converting 0x99: no commit, display blank, idle.
    pulse_load(8'h99);
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'h0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy_o);
      done_cnt += int'(done_o);
    end
    chk("abort_busy_after", 32'(busy_cnt), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    repeat (80) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
